// File: rtl/audio_i2s_rx.sv
// Stereo I2S receiver: oversamples sclk/lrck/sdata on the system clock and
// deserialises left/right words. Pairs are released to the outputs only on clken48kHz.
module audio_i2s_rx #(
  parameter int BITS = 18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clken48kHz,
  input  logic                   sclk,
  input  logic                   lrck,
  input  logic                   sdata,
  output logic signed [BITS-1:0] LEFTout,
  output logic signed [BITS-1:0] RIGHTout,
  output logic                   sample_valid,
  output logic                   overrun,
  output logic                   underrun
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  logic [2:0]      sclk_sync_q;
  logic [1:0]      lrck_sync_q, sdata_sync_q;
  logic            lrck_prev_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, idx;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [BITS-1:0] left_hold_q, left_hold_d;
  logic            left_valid_q, left_valid_d;
  logic [BITS-1:0] stage_l_q, stage_r_q;
  logic            pair_ready_q;
  logic signed [BITS-1:0] left_out_q, right_out_q;
  logic            valid_q, ovr_q, und_q;

  logic sclk_rise, lr, sd, lr_chg, pair_done;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign lr        = lrck_sync_q[1];
  assign sd        = sdata_sync_q[1];
  assign lr_chg    = sclk_rise && (lr != lrck_prev_q);
  assign idx       = CW'(BITS - 1) - cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q;
    pair_done    = 1'b0;
    case (state_q)
      IDLE: begin
        left_valid_d = 1'b0;
        if (lr_chg && !lr) state_d = SKIP;
      end
      // Delay-slot bit was dropped on the change edge; arm for the MSB.
      SKIP: begin
        cnt_d   = '0;
        shreg_d = '0;
        state_d = SHIFT;
      end
      SHIFT, HOLD: begin
        if (lr_chg) begin
          // shreg is cleared at word start, so short words are already zero-filled
          if (lr) begin
            left_hold_d  = shreg_q;
            left_valid_d = 1'b1;
          end else if (left_valid_q) begin
            pair_done = 1'b1;
          end
          cnt_d   = '0;
          shreg_d = '0;
          state_d = SHIFT;
        end else if (sclk_rise && state_q == SHIFT) begin
          shreg_d[idx] = sd;
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == CW'(BITS - 1)) state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      lrck_prev_q  <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
      lrck_sync_q  <= {lrck_sync_q[0], lrck};
      sdata_sync_q <= {sdata_sync_q[0], sdata};
      if (sclk_rise) lrck_prev_q <= lr;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
    end
  end

  // Strobe consumes the old staging before a coincident pair overwrites it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_l_q    <= '0;
      stage_r_q    <= '0;
      pair_ready_q <= 1'b0;
      left_out_q   <= '0;
      right_out_q  <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clken48kHz) begin
        if (pair_ready_q) begin
          left_out_q  <= stage_l_q;
          right_out_q <= stage_r_q;
          valid_q     <= 1'b1;
        end else begin
          und_q <= 1'b1;
        end
      end
      if (pair_done) begin
        stage_l_q    <= left_hold_q;
        stage_r_q    <= shreg_q;
        pair_ready_q <= 1'b1;
        if (pair_ready_q && !clken48kHz) ovr_q <= 1'b1;
      end else if (clken48kHz) begin
        pair_ready_q <= 1'b0;
      end
    end
  end

  assign LEFTout      = left_out_q;
  assign RIGHTout     = right_out_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Directed + randomized bench for audio_i2s_rx against a transaction-level
// model of word capture, staging and strobe release.
module tb_audio_i2s_rx;
  localparam int BITS = 18;
  localparam int HP   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1, clken48kHz = 1'b0, sclk = 1'b0, lrck = 1'b0, sdata = 1'b0;
  logic [BITS-1:0] LEFTout, RIGHTout;
  logic sample_valid, overrun, underrun;

  audio_i2s_rx #(.BITS(BITS)) dut (
    .clock(clock), .reset(reset), .clken48kHz(clken48kHz),
    .sclk(sclk), .lrck(lrck), .sdata(sdata),
    .LEFTout(LEFTout), .RIGHTout(RIGHTout),
    .sample_valid(sample_valid), .overrun(overrun), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int vcount = 0;
  always @(posedge clock) begin
    #2;
    if (sample_valid === 1'b1) vcount++;
  end

  // model state
  logic [17:0] m_l, m_r, st_l, st_r, op_l, op_r, pend_l;
  bit m_ready, m_ovr, m_und, m_valid, op_valid, l_have, cur_lr;
  int m_vcount = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".L"}, 32'(LEFTout), 32'(m_l));
    chk({tag, ".R"}, 32'(RIGHTout), 32'(m_r));
    chk({tag, ".valid"}, 32'(sample_valid), 32'(m_valid));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".und"}, 32'(underrun), 32'(m_und));
    chk({tag, ".npulses"}, 32'(vcount), 32'(m_vcount));
  endtask

  function automatic logic [17:0] cap(logic [31:0] w, int nb);
    if (nb >= 18) return 18'(w >> (nb - 18));
    return 18'(w << (18 - nb));
  endfunction

  // Strobe is applied first, then a coincident completion lands in staging.
  task automatic model_event(bit strb, bit comp, logic [17:0] nl, logic [17:0] nr);
    bit old = m_ready;
    m_valid = 1'b0;
    if (strb) begin
      if (m_ready) begin
        m_l = st_l; m_r = st_r; m_valid = 1'b1; m_vcount++; m_ready = 1'b0;
      end else m_und = 1'b1;
    end
    if (comp) begin
      if (old && !strb) m_ovr = 1'b1;
      st_l = nl; st_r = nr; m_ready = 1'b1;
    end
  endtask

  // One bit slot; optional strobe lands on the cycle the DUT acts on this rise.
  task automatic slot(bit lr, bit d, bit strb);
    @(negedge clock); lrck = lr; sdata = d;
    repeat (HP) @(negedge clock);
    sclk = 1'b1;
    @(negedge clock);
    @(negedge clock);
    if (strb) clken48kHz = 1'b1;
    @(negedge clock);
    clken48kHz = 1'b0;
    if (strb) check_all("coinc");
    @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic change(bit lr, bit strb);
    bit comp = (lr == 1'b0) && op_valid;
    if (comp || strb) model_event(strb, comp, op_l, op_r);
    if (comp) op_valid = 1'b0;
    cur_lr = lr;
    slot(lr, 1'($urandom), strb);
  endtask

  task automatic send_word(bit ch, logic [31:0] w, int nb);
    if (cur_lr != ch) change(ch, 1'b0);
    for (int i = nb - 1; i >= 0; i--) slot(ch, w[i], 1'b0);
    if (ch == 1'b0) begin
      pend_l = cap(w, nb); l_have = 1'b1;
    end else if (l_have) begin
      op_l = pend_l; op_r = cap(w, nb); op_valid = 1'b1;
    end
  endtask

  task automatic send_pair(logic [31:0] l, int lb, logic [31:0] r, int rb);
    send_word(1'b0, l, lb);
    send_word(1'b1, r, rb);
  endtask

  task automatic close(bit strb);
    if (cur_lr != 1'b0) change(1'b0, strb);
  endtask

  task automatic strobe(string tag);
    repeat (3) @(negedge clock);
    clken48kHz = 1'b1;
    model_event(1'b1, 1'b0, '0, '0);
    @(negedge clock);
    clken48kHz = 1'b0;
    check_all(tag);
    @(negedge clock);
    chk({tag, ".pulse"}, 32'(sample_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_l = '0; m_r = '0; st_l = '0; st_r = '0; m_ready = 0; m_ovr = 0; m_und = 0;
    m_valid = 0; op_valid = 0; l_have = 0;
    check_all("reset");
  endtask

  task automatic preamble();
    slot(1'b1, 1'($urandom), 1'b0);
    slot(1'b1, 1'($urandom), 1'b0);
    cur_lr = 1'b1;
  endtask

  function automatic logic [31:0] pad(logic [17:0] v);
    return (32'(v) << 13) | ($urandom & 32'h1FFF);
  endfunction

  initial begin
    logic [17:0] lv, rv;
    int lb, rb;
    // reset then idle strobes
    do_reset();
    for (int i = 0; i < 4; i++) strobe("idle");

    // nominal frame then ramp
    do_reset();
    preamble();
    lv = 18'h0008C; rv = 18'h00020;
    send_pair(pad(lv), 31, pad(rv), 31);
    close(1'b0);
    strobe("nominal");
    for (int i = 0; i < 8; i++) begin
      lv += 18'd5; rv += 18'd7;
      send_pair(pad(lv), 31, pad(rv), 31);
      close(1'b0);
      strobe("ramp");
    end

    // short / long words
    send_pair(32'h8001, 16, $urandom & 32'hFFFFFF, 24);
    close(1'b0);
    strobe("shortlong");

    // randomized word lengths and values
    for (int i = 0; i < 6; i++) begin
      lb = int'($urandom_range(12, 31));
      rb = int'($urandom_range(12, 31));
      send_pair($urandom, lb, $urandom, rb);
      close(1'b0);
      strobe("rand");
    end

    // overrun
    do_reset();
    preamble();
    send_pair(32'd1, 18, 32'd2, 18);
    send_pair(32'd3, 18, 32'd4, 18);
    close(1'b0);
    strobe("overrun");

    // reset mid-word
    change(1'b1, 1'b0);
    change(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) slot(1'b0, 1'($urandom), 1'b0);
    do_reset();
    preamble();
    send_pair(32'h3FFFF, 18, 32'd5, 18);
    close(1'b0);
    strobe("midreset");

    // pair completing on the strobe cycle, staging full then empty
    do_reset();
    preamble();
    send_pair(pad(18'h11111), 31, pad(18'h22222), 31);
    send_pair(pad(18'h33333), 31, pad(18'h04444), 31);
    close(1'b1);
    strobe("coinc_full");
    send_pair(pad(18'h05555), 31, pad(18'h26666), 31);
    close(1'b1);
    strobe("coinc_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
